// File: rtl/fifo_stream_reader_pkg.sv
// Shared constants and types for the FIFO-to-stream reader and its skid buffer.
package fifo_stream_reader_pkg;

    localparam int unsigned SKID_DEPTH = 3;

    typedef logic [1:0] skid_ptr_t;
    typedef logic [1:0] skid_occ_t;

    // Pointer increment that wraps at SKID_DEPTH rather than at the type's range.
    function automatic skid_ptr_t ptr_inc(input skid_ptr_t p);
        return (p == skid_ptr_t'(SKID_DEPTH - 1)) ? '0 : p + skid_ptr_t'(1);
    endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// FIFO read port plus outgoing valid/ready stream; master is the reader side.
interface fifo_stream_reader_if #(
    parameter int unsigned p_bitwidth = 32
);
    logic                  fifo_empty;
    logic [p_bitwidth-1:0] fifo_rd_data;
    logic                  fifo_rd_en;
    logic                  out_val;
    logic                  out_rdy;
    logic [p_bitwidth-1:0] out_msg;

    modport master (
        input  fifo_empty, fifo_rd_data, out_rdy,
        output fifo_rd_en, out_val, out_msg
    );

    modport slave (
        output fifo_empty, fifo_rd_data, out_rdy,
        input  fifo_rd_en, out_val, out_msg
    );
endinterface

// File: rtl/fifo_stream_reader_skid.sv
// Three-entry circular skid buffer: tail write port, head read, occupancy, sync clear.
module fifo_stream_reader_skid
    import fifo_stream_reader_pkg::*;
#(
    parameter int unsigned p_bitwidth = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear_i,
    input  logic                  wr_en_i,
    input  logic [p_bitwidth-1:0] wr_data_i,
    input  logic                  rd_en_i,
    output logic [p_bitwidth-1:0] rd_data_o,
    output skid_occ_t             occ_o
);
    logic [p_bitwidth-1:0] mem_q [SKID_DEPTH];
    logic [p_bitwidth-1:0] mem_d [SKID_DEPTH];
    skid_ptr_t             head_q, head_d;
    skid_ptr_t             tail_q, tail_d;
    skid_occ_t             occ_q, occ_d;

    always_comb begin
        mem_d  = mem_q;
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        if (clear_i) begin
            head_d = '0;
            tail_d = '0;
            occ_d  = '0;
        end else begin
            if (wr_en_i) begin
                mem_d[tail_q] = wr_data_i;
                tail_d        = ptr_inc(tail_q);
            end
            if (rd_en_i) begin
                head_d = ptr_inc(head_q);
            end
            case ({wr_en_i, rd_en_i})
                2'b10:   occ_d = occ_q + skid_occ_t'(1);
                2'b01:   occ_d = occ_q - skid_occ_t'(1);
                default: occ_d = occ_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SKID_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
        end else begin
            mem_q  <= mem_d;
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    assign rd_data_o = mem_q[head_q];
    assign occ_o     = occ_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a one-cycle-latency FIFO into a valid/ready stream via a credit-controlled skid buffer.
// Define FIFO_STREAM_READER_COUNT_EN to build the xfer_count handshake counter.
module fifo_stream_reader
    import fifo_stream_reader_pkg::*;
#(
    parameter int unsigned p_bitwidth    = 32,
    parameter int unsigned p_count_width = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    fifo_stream_reader_if.master     bus,
    output logic [p_count_width-1:0] xfer_count
);
    logic      inflight_q, inflight_d;
    skid_occ_t occ;
    logic      rd_en;
    logic      fire;
    logic [2:0] credit_used;

    // Credits count both buffered entries and the word still on the FIFO read bus.
    assign credit_used = {1'b0, occ} + {2'b00, inflight_q};

    // Gated by rst_n so no pop is requested while held in reset.
    assign rd_en = rst_n && !bus.fifo_empty && !clear && (credit_used < 3'(SKID_DEPTH));

    assign bus.fifo_rd_en = rd_en;
    assign bus.out_val    = (occ != '0);
    assign fire           = bus.out_val && bus.out_rdy;
    assign inflight_d     = rd_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

    fifo_stream_reader_skid #(
        .p_bitwidth (p_bitwidth)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (clear),
        .wr_en_i   (inflight_q && !clear),
        .wr_data_i (bus.fifo_rd_data),
        .rd_en_i   (fire),
        .rd_data_o (bus.out_msg),
        .occ_o     (occ)
    );

`ifdef FIFO_STREAM_READER_COUNT_EN
    logic [p_count_width-1:0] count_q, count_d;

    assign count_d = fire ? count_q + (p_count_width)'(1) : count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign xfer_count = count_q;
`else
    assign xfer_count = '0;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Randomized self-checking bench for fifo_stream_reader against a pop-order/latency model.
// Counter expectations follow FIFO_STREAM_READER_COUNT_EN.
module tb_fifo_stream_reader;
    localparam int unsigned W  = 32;
    localparam int unsigned CW = 4;

`ifdef FIFO_STREAM_READER_COUNT_EN
    localparam logic [CW-1:0] CNT_AFTER_8  = 4'd8;
    localparam logic [CW-1:0] CNT_AFTER_17 = 4'd1;
`else
    localparam logic [CW-1:0] CNT_AFTER_8  = 4'd0;
    localparam logic [CW-1:0] CNT_AFTER_17 = 4'd0;
`endif

    typedef struct {
        logic [W-1:0] data;
        int unsigned  cyc;
    } item_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          clear = 1'b0;
    logic          out_rdy = 1'b0;
    logic [CW-1:0] xfer_count;

    fifo_stream_reader_if #(.p_bitwidth(W)) bus ();

    fifo_stream_reader #(
        .p_bitwidth    (W),
        .p_count_width (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .bus        (bus),
        .xfer_count (xfer_count)
    );

    always #5 clk = ~clk;

    // Source FIFO with registered read data; never reset so its head survives a DUT reset.
    logic [W-1:0] fifo_mem [1024];
    logic [9:0]   wr_ptr = '0;
    logic [9:0]   rd_ptr = '0;
    logic [W-1:0] rd_data_q = '0;

    assign bus.fifo_empty   = (rd_ptr == wr_ptr);
    assign bus.fifo_rd_data = rd_data_q;
    assign bus.out_rdy      = out_rdy;

    always @(posedge clk) begin
        if (bus.fifo_rd_en) begin
            rd_data_q <= fifo_mem[rd_ptr];
            rd_ptr    <= rd_ptr + 10'd1;
        end
    end

    // Model: popped words reach the stream in pop order, two cycles after their pop,
    // with at most three popped-but-undelivered; clear and reset drop them all.
    item_t         mq[$];
    logic [W-1:0]  pend_q[$];
    int unsigned   now = 0;
    logic [CW-1:0] exp_count = '0;
    int            checks = 0;
    int            errors = 0;

    task automatic drive_cycle(input logic rdy, input logic clr,
                               output logic av, output logic [W-1:0] am, output logic ard,
                               output logic aemp, output logic [CW-1:0] ac,
                               output logic ev, output logic [W-1:0] em, output logic erd,
                               output logic [CW-1:0] ec);
        @(negedge clk);
        while (pend_q.size() != 0) begin
            fifo_mem[wr_ptr] = pend_q.pop_front();
            wr_ptr = wr_ptr + 10'd1;
        end
        out_rdy = rdy;
        clear   = clr;
        #1;
        av   = bus.out_val;
        am   = bus.out_msg;
        ard  = bus.fifo_rd_en;
        aemp = bus.fifo_empty;
        ac   = xfer_count;
        ev   = (mq.size() != 0) && (mq[0].cyc + 2 <= now);
        em   = (mq.size() != 0) ? mq[0].data : '0;
        erd  = !aemp && !clr && (mq.size() < 3);
        ec   = exp_count;
        if (ev && rdy) begin
            void'(mq.pop_front());
`ifdef FIFO_STREAM_READER_COUNT_EN
            exp_count = exp_count + CW'(1);
`endif
        end
        if (clr) mq.delete();
        if (ard) mq.push_back('{data: fifo_mem[rd_ptr], cyc: now});
        now++;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #11;
        checks++; if (bus.out_val !== 1'b0) begin errors++; $display("FAIL reset_val got %b exp 0", bus.out_val); end
        checks++; if (bus.fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got %b exp 0", bus.fifo_rd_en); end
        checks++; if (bus.out_msg !== '0) begin errors++; $display("FAIL reset_msg got %h exp 0", bus.out_msg); end
        checks++; if (xfer_count !== '0) begin errors++; $display("FAIL reset_count got %0d exp 0", xfer_count); end
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic av, ard, aemp, ev, erd;
        logic [W-1:0] am, em;
        logic [CW-1:0] ac, ec;
        int got, first;
        got = 0; first = -1;
        for (int i = 0; i < 8; i++) pend_q.push_back(W'(32'h11 + i));
        for (int c = 0; c < 20 && got < 8; c++) begin
            drive_cycle(1'b1, 1'b0, av, am, ard, aemp, ac, ev, em, erd, ec);
            if (c == 0) begin
                checks++; if (ard !== 1'b1) begin errors++; $display("FAIL basic_first_pop got %b exp 1", ard); end
            end
            checks++; if (av !== ev) begin errors++; $display("FAIL basic_val c%0d got %b exp %b", c, av, ev); end
            checks++; if (ard !== erd) begin errors++; $display("FAIL basic_rd_en c%0d got %b exp %b", c, ard, erd); end
            checks++; if (ac !== ec) begin errors++; $display("FAIL basic_count c%0d got %0d exp %0d", c, ac, ec); end
            if (ev) begin
                checks++; if (am !== em) begin errors++; $display("FAIL basic_msg c%0d got %h exp %h", c, am, em); end
            end
            if (av) begin
                if (first < 0) first = c;
                checks++; if (am !== W'(32'h11 + got)) begin errors++; $display("FAIL basic_seq c%0d got %h exp %h", c, am, 32'h11 + got); end
                got++;
            end
        end
        checks++; if (first != 2) begin errors++; $display("FAIL basic_latency got %0d exp 2", first); end
        checks++; if (got != 8) begin errors++; $display("FAIL basic_delivered got %0d exp 8", got); end
        drive_cycle(1'b1, 1'b0, av, am, ard, aemp, ac, ev, em, erd, ec);
        checks++; if (ac !== CNT_AFTER_8) begin errors++; $display("FAIL basic_xfer_count got %0d exp %0d", ac, CNT_AFTER_8); end
        checks++; if (av !== 1'b0) begin errors++; $display("FAIL basic_drained got %b exp 0", av); end
    endtask

    task automatic test_stall();
        logic av, ard, aemp, ev, erd, r;
        logic [W-1:0] am, em;
        logic [CW-1:0] ac, ec;
        int got, pops;
        got = 0; pops = 0;
        for (int i = 0; i < 8; i++) pend_q.push_back(W'(32'h11 + i));
        for (int c = 0; c < 40 && got < 8; c++) begin
            r = (c >= 10);
            drive_cycle(r, 1'b0, av, am, ard, aemp, ac, ev, em, erd, ec);
            checks++; if (av !== ev) begin errors++; $display("FAIL stall_val c%0d got %b exp %b", c, av, ev); end
            checks++; if (ard !== erd) begin errors++; $display("FAIL stall_rd_en c%0d got %b exp %b", c, ard, erd); end
            checks++; if (ac !== ec) begin errors++; $display("FAIL stall_count c%0d got %0d exp %0d", c, ac, ec); end
            if (ev) begin
                checks++; if (am !== em) begin errors++; $display("FAIL stall_msg c%0d got %h exp %h", c, am, em); end
            end
            if (c < 10) begin
                if (ard) pops++;
                if (av) begin
                    checks++; if (am !== 32'h11) begin errors++; $display("FAIL stall_hold c%0d got %h exp 11", c, am); end
                end
            end
            if (av && r) got++;
            if (c == 9) begin
                checks++; if (pops != 3) begin errors++; $display("FAIL stall_pops got %0d exp 3", pops); end
            end
        end
        checks++; if (got != 8) begin errors++; $display("FAIL stall_delivered got %0d exp 8", got); end
    endtask

    task automatic test_toggle();
        logic av, ard, aemp, ev, erd, r;
        logic [W-1:0] am, em;
        logic [CW-1:0] ac, ec;
        int got;
        got = 0;
        for (int i = 0; i < 20; i++) pend_q.push_back($urandom());
        for (int c = 0; c < 100 && got < 20; c++) begin
            r = (c % 2 == 0);
            drive_cycle(r, 1'b0, av, am, ard, aemp, ac, ev, em, erd, ec);
            checks++; if (av !== ev) begin errors++; $display("FAIL toggle_val c%0d got %b exp %b", c, av, ev); end
            checks++; if (ard !== erd) begin errors++; $display("FAIL toggle_rd_en c%0d got %b exp %b", c, ard, erd); end
            checks++; if (ard && aemp) begin errors++; $display("FAIL toggle_pop_empty c%0d got 1 exp 0", c); end
            if (ev) begin
                checks++; if (am !== em) begin errors++; $display("FAIL toggle_msg c%0d got %h exp %h", c, am, em); end
            end
            if (av && r) got++;
        end
        checks++; if (got != 20) begin errors++; $display("FAIL toggle_delivered got %0d exp 20", got); end
    endtask

    task automatic test_random();
        logic av, ard, aemp, ev, erd, r;
        logic [W-1:0] am, em;
        logic [CW-1:0] ac, ec;
        int pushed, got;
        pushed = 0; got = 0;
        for (int c = 0; c < 200 && !(c >= 80 && got == pushed); c++) begin
            if (c < 80 && $urandom_range(0, 1) == 1) begin
                pend_q.push_back($urandom());
                pushed++;
            end
            r = (c >= 80) ? 1'b1 : 1'($urandom_range(0, 1));
            drive_cycle(r, 1'b0, av, am, ard, aemp, ac, ev, em, erd, ec);
            checks++; if (av !== ev) begin errors++; $display("FAIL random_val c%0d got %b exp %b", c, av, ev); end
            checks++; if (ard !== erd) begin errors++; $display("FAIL random_rd_en c%0d got %b exp %b", c, ard, erd); end
            checks++; if (ac !== ec) begin errors++; $display("FAIL random_count c%0d got %0d exp %0d", c, ac, ec); end
            if (ev) begin
                checks++; if (am !== em) begin errors++; $display("FAIL random_msg c%0d got %h exp %h", c, am, em); end
            end
            if (av && r) got++;
        end
        checks++; if (got != pushed) begin errors++; $display("FAIL random_delivered got %0d exp %0d", got, pushed); end
    endtask

    task automatic test_clear();
        logic av, ard, aemp, ev, erd;
        logic [W-1:0] am, em;
        logic [CW-1:0] ac, ec;
        logic [W-1:0] vals [6];
        int got;
        got = 0;
        for (int i = 0; i < 6; i++) begin
            vals[i] = $urandom();
            pend_q.push_back(vals[i]);
        end
        // Pops in cycles 0..2 leave two buffered plus one in flight when clear hits in cycle 3.
        for (int c = 0; c < 4; c++) begin
            drive_cycle(1'b0, (c == 3), av, am, ard, aemp, ac, ev, em, erd, ec);
            checks++; if (ard !== erd) begin errors++; $display("FAIL clear_rd_en c%0d got %b exp %b", c, ard, erd); end
            checks++; if (av !== ev) begin errors++; $display("FAIL clear_val c%0d got %b exp %b", c, av, ev); end
        end
        for (int c = 4; c < 30 && got < 3; c++) begin
            drive_cycle(1'b1, 1'b0, av, am, ard, aemp, ac, ev, em, erd, ec);
            if (c == 4) begin
                checks++; if (av !== 1'b0) begin errors++; $display("FAIL clear_flushed got %b exp 0", av); end
            end
            checks++; if (av !== ev) begin errors++; $display("FAIL clear_val c%0d got %b exp %b", c, av, ev); end
            checks++; if (ard !== erd) begin errors++; $display("FAIL clear_rd_en c%0d got %b exp %b", c, ard, erd); end
            if (av) begin
                checks++; if (am !== vals[3 + got]) begin errors++; $display("FAIL clear_next c%0d got %h exp %h", c, am, vals[3 + got]); end
                got++;
            end
        end
        checks++; if (got != 3) begin errors++; $display("FAIL clear_delivered got %0d exp 3", got); end
    endtask

    task automatic test_reset_mid();
        logic av, ard, aemp, ev, erd;
        logic [W-1:0] am, em;
        logic [CW-1:0] ac, ec;
        logic [W-1:0] head_val;
        logic [9:0] head;
        int got, remain;
        got = 0;
        for (int i = 0; i < 10; i++) pend_q.push_back($urandom());
        for (int c = 0; c < 4; c++) begin
            drive_cycle(1'b1, 1'b0, av, am, ard, aemp, ac, ev, em, erd, ec);
            checks++; if (av !== ev) begin errors++; $display("FAIL rstmid_val c%0d got %b exp %b", c, av, ev); end
        end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (bus.out_val !== 1'b0) begin errors++; $display("FAIL rstmid_val got %b exp 0", bus.out_val); end
        checks++; if (bus.fifo_rd_en !== 1'b0) begin errors++; $display("FAIL rstmid_rd_en got %b exp 0", bus.fifo_rd_en); end
        checks++; if (xfer_count !== '0) begin errors++; $display("FAIL rstmid_count got %0d exp 0", xfer_count); end
        mq.delete();
        exp_count = '0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        head = rd_ptr;
        head_val = fifo_mem[head];
        remain = int'(wr_ptr - rd_ptr);
        for (int c = 0; c < 40 && got < remain; c++) begin
            drive_cycle(1'b1, 1'b0, av, am, ard, aemp, ac, ev, em, erd, ec);
            checks++; if (av !== ev) begin errors++; $display("FAIL rstmid_val c%0d got %b exp %b", c, av, ev); end
            checks++; if (ac !== ec) begin errors++; $display("FAIL rstmid_count c%0d got %0d exp %0d", c, ac, ec); end
            if (ev) begin
                checks++; if (am !== em) begin errors++; $display("FAIL rstmid_msg c%0d got %h exp %h", c, am, em); end
            end
            if (av) begin
                if (got == 0) begin
                    checks++; if (am !== head_val) begin errors++; $display("FAIL rstmid_restart got %h exp %h", am, head_val); end
                end
                got++;
            end
        end
        checks++; if (got != remain) begin errors++; $display("FAIL rstmid_delivered got %0d exp %0d", got, remain); end
    endtask

    task automatic test_count();
        logic av, ard, aemp, ev, erd;
        logic [W-1:0] am, em;
        logic [CW-1:0] ac, ec;
        int got;
        got = 0;
        #1 rst_n = 1'b0;
        mq.delete();
        exp_count = '0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 17; i++) pend_q.push_back($urandom());
        for (int c = 0; c < 40 && got < 17; c++) begin
            drive_cycle(1'b1, 1'b0, av, am, ard, aemp, ac, ev, em, erd, ec);
            checks++; if (ac !== ec) begin errors++; $display("FAIL count_step c%0d got %0d exp %0d", c, ac, ec); end
            if (ev) begin
                checks++; if (am !== em) begin errors++; $display("FAIL count_msg c%0d got %h exp %h", c, am, em); end
            end
            if (av) got++;
        end
        drive_cycle(1'b1, 1'b0, av, am, ard, aemp, ac, ev, em, erd, ec);
        checks++; if (got != 17) begin errors++; $display("FAIL count_delivered got %0d exp 17", got); end
        checks++; if (ac !== CNT_AFTER_17) begin errors++; $display("FAIL count_wrap got %0d exp %0d", ac, CNT_AFTER_17); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_toggle();
        test_random();
        test_clear();
        test_reset_mid();
        test_count();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
